// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that moves whole blocks between N requester ports and a beat-wide bus.
// The write path is built only when MEM_PORT_ARBITER_WRITE_EN is defined; otherwise every request is a read.
module mem_port_arbiter #(
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned BLOCKSZ        = 512
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS-1:0]          port_req,
  input  logic [N_PORTS-1:0]          port_wr,
  input  logic [N_PORTS*64-1:0]       port_addr,
  input  logic [N_PORTS*BLOCKSZ-1:0]  port_wdata,
  output logic [BLOCKSZ-1:0]          port_rdata,
  output logic [N_PORTS-1:0]          port_done,
  output logic                        bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]   bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
  input  logic                        bus_reqack,
  input  logic                        bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
  output logic                        bus_respack
);

  localparam int unsigned BEATS     = BLOCKSZ / BUS_DATA_WIDTH;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IDX_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [63:0] ADDR_MASK = ~64'(BLOCKSZ / 8 - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic [CNT_W-1:0]   beat_cnt;
  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic               rw_next;
  logic [63:0]        addr_arr [N_PORTS];

  for (genvar i = 0; i < int'(N_PORTS); i++) begin : g_addr
    assign addr_arr[i] = port_addr[i*64 +: 64];
  end

  // Round-robin pick: lowest offset from rr_ptr with a pending request wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = int'(N_PORTS) - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(rr_ptr) + off) % int'(N_PORTS));
      if (port_req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign bus_respack = (state == RDATA) && bus_respcyc;

`ifdef MEM_PORT_ARBITER_WRITE_EN
  logic                      rw_q;
  logic [BLOCKSZ-1:0]        wdata_q;
  logic [BLOCKSZ-1:0]        wdata_arr [N_PORTS];
  logic [CNT_W-1:0]          wbeat_idx;
  logic [BUS_DATA_WIDTH-1:0] wbeat;
  logic                      unused_inputs;

  for (genvar i = 0; i < int'(N_PORTS); i++) begin : g_wdata
    assign wdata_arr[i] = port_wdata[i*BLOCKSZ +: BLOCKSZ];
  end

  assign rw_next       = ~port_wr[gnt_idx];
  assign unused_inputs = ^bus_resptag;

  // Beat to present next: beat 0 on the address ack, otherwise the one after beat_cnt
  assign wbeat_idx = (state == ADDR) ? '0 : beat_cnt + CNT_W'(1);
  always_comb begin
    wbeat = '0;
    for (int k = 0; k < int'(BEATS); k++) begin
      if (wbeat_idx == CNT_W'(k)) wbeat = wdata_q[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end
  end
`else
  logic unused_inputs;
  assign rw_next       = 1'b1;
  assign unused_inputs = ^{port_wr, port_wdata, bus_resptag};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      beat_cnt   <= '0;
      port_rdata <= '0;
      port_done  <= '0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      bus_reqtag <= '0;
`ifdef MEM_PORT_ARBITER_WRITE_EN
      rw_q       <= 1'b1;
      wdata_q    <= '0;
`endif
    end else begin
      port_done <= '0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            grant      <= gnt_idx;
            bus_reqcyc <= 1'b1;
            bus_req    <= BUS_DATA_WIDTH'(addr_arr[gnt_idx] & ADDR_MASK);
            bus_reqtag <= BUS_TAG_WIDTH'({rw_next, 4'h1, 8'(gnt_idx)});
`ifdef MEM_PORT_ARBITER_WRITE_EN
            rw_q       <= rw_next;
            wdata_q    <= wdata_arr[gnt_idx];
`endif
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (bus_reqack) begin
            beat_cnt <= '0;
`ifdef MEM_PORT_ARBITER_WRITE_EN
            if (!rw_q) begin
              bus_req <= wbeat;
              state   <= WDATA;
            end else begin
              bus_reqcyc <= 1'b0;
              bus_req    <= '0;
              state      <= RDATA;
            end
`else
            bus_reqcyc <= 1'b0;
            bus_req    <= '0;
            state      <= RDATA;
`endif
          end
        end
        WDATA: begin
`ifdef MEM_PORT_ARBITER_WRITE_EN
          if (bus_reqack) begin
            if (beat_cnt == LAST_BEAT) begin
              bus_reqcyc <= 1'b0;
              bus_req    <= '0;
              bus_reqtag <= '0;
              port_done  <= N_PORTS'(1) << grant;
              state      <= DONE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
              bus_req  <= wbeat;
            end
          end
`else
          state <= IDLE;
`endif
        end
        RDATA: begin
          if (bus_respcyc) begin
            for (int k = 0; k < int'(BEATS); k++) begin
              if (beat_cnt == CNT_W'(k)) port_rdata[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_resp;
            end
            if (beat_cnt == LAST_BEAT) begin
              bus_reqtag <= '0;
              port_done  <= N_PORTS'(1) << grant;
              state      <= DONE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          beat_cnt <= '0;
          rr_ptr   <= (grant == IDX_W'(N_PORTS - 1)) ? '0 : grant + IDX_W'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small bus responder (ack delay, response gaps, stray beats).
// Checks adapt to MEM_PORT_ARBITER_WRITE_EN so the same file covers both builds.
module tb_mem_port_arbiter;
  localparam int unsigned NP = 2, DW = 64, TW = 13, BSZ = 512, BEATS = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     port_req;
  logic [NP-1:0]     port_wr;
  logic [NP*64-1:0]  port_addr;
  logic [NP*BSZ-1:0] port_wdata;
  logic [BSZ-1:0]    port_rdata;
  logic [NP-1:0]     port_done;
  logic              bus_reqcyc;
  logic [DW-1:0]     bus_req;
  logic [TW-1:0]     bus_reqtag;
  logic              bus_reqack = 1'b0;
  logic              bus_respcyc = 1'b0;
  logic [DW-1:0]     bus_resp = '0;
  logic [TW-1:0]     bus_resptag = '0;
  logic              bus_respack;

  mem_port_arbiter #(.N_PORTS(NP), .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BLOCKSZ(BSZ)) dut (
    .clk(clk), .reset(reset), .port_req(port_req), .port_wr(port_wr), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_rdata(port_rdata), .port_done(port_done),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus responder: drives on the falling edge, DUT samples on the rising edge
  int          ack_delay = 0;
  bit          gap_en = 0;
  bit          junk_en = 0;
  int          beat_base = 0;
  int          addr_wait = 0;
  bit          addr_pend = 0;
  int          rd_left = 0;
  int          rd_k = 0;
  int          wr_left = 0;
  bit          beat_out = 0;
  bit          took = 0;
  bit          unstable = 0;
  logic [63:0] addr_seen = '0;
  logic [12:0] tag_seen = '0;
  logic [63:0] wr_log [BEATS];

  always @(negedge clk) begin
    if (reset) begin
      bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
      addr_wait = 0; addr_pend = 0; rd_left = 0; rd_k = 0; wr_left = 0; beat_out = 0;
    end else begin
      took = beat_out;
      if (took) begin rd_k++; rd_left--; end
      bus_respcyc = 1'b0; bus_resp = '0; bus_reqack = 1'b0; beat_out = 0;
      if (rd_left > 0 && !(gap_en && took)) begin
        bus_respcyc = 1'b1; bus_resp = 64'(beat_base + rd_k); beat_out = 1;
      end else if (junk_en) begin
        bus_respcyc = 1'b1; bus_resp = 64'hDEAD_BEEF;
      end
      if (bus_reqcyc) begin
        if (wr_left > 0) begin
          bus_reqack = 1'b1;
          wr_log[BEATS - wr_left] = bus_req;
          wr_left--;
        end else begin
          if (!addr_pend) begin
            addr_pend = 1; addr_wait = 0; addr_seen = bus_req; tag_seen = bus_reqtag;
          end else if (bus_req !== addr_seen || bus_reqtag !== tag_seen) begin
            unstable = 1;
          end
          if (addr_wait >= ack_delay) begin
            bus_reqack = 1'b1; addr_pend = 0;
            if (bus_reqtag[12]) begin rd_left = BEATS; rd_k = 0; end
            else wr_left = BEATS;
          end else begin
            addr_wait++;
          end
        end
      end
    end
  end

  // Count cycles from a request seen in IDLE (cycle `start`) up to the port_done cycle
  task automatic wait_done(input int p, input int start, output int cyc);
    cyc = start;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (port_done != '0) begin
        check_val($sformatf("done_vec_p%0d", p), 64'(port_done), 64'(1 << p));
        port_req[p] = 1'b0;
        return;
      end
    end
    check_val("done_timeout", 64'(cyc), 64'(0));
    cyc = -1;
  endtask

  task automatic check_block(input string tag, input int base);
    for (int k = 0; k < int'(BEATS); k++)
      check_val($sformatf("%s_b%0d", tag, k), port_rdata[k*64 +: 64], 64'(base + k));
  endtask

  task automatic next_cycle_quiet(input string tag);
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, 64'(port_done), 64'(0));
  endtask

  int cyc;

  initial begin
    reset = 1'b1; port_req = '0; port_wr = '0; port_addr = '0; port_wdata = '0;
    for (int k = 0; k < int'(BEATS); k++) port_wdata[BSZ + k*64 +: 64] = 64'(8'hB0 + k);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_done", 64'(port_done), 64'(0));
    check_val("rst_reqcyc", 64'(bus_reqcyc), 64'(0));
    check_val("rst_req", bus_req, 64'(0));
    check_val("rst_tag", 64'(bus_reqtag), 64'(0));
    check_val("rst_respack", 64'(bus_respack), 64'(0));
    check_val("rst_rdata", 64'(|port_rdata), 64'(0));
    reset = 1'b0;

    // Plain read, immediate ack, back-to-back beats
    @(posedge clk); #1;
    port_addr[63:0] = 64'h1008; port_addr[127:64] = 64'h3040;
    beat_base = 'hA0; unstable = 0; port_req[0] = 1'b1;
    wait_done(0, 1, cyc);
    check_val("rd_latency", 64'(cyc), 64'(11));
    check_val("rd_addr", addr_seen, 64'h1000);
    check_val("rd_tag", 64'(tag_seen), 64'h1100);
    check_block("rd", 'hA0);
    next_cycle_quiet("rd");
    check_val("rd_reqcyc_idle", 64'(bus_reqcyc), 64'(0));

    // Contention from reset: grants alternate 0,1,0,1
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    port_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done(i % 2, 1, cyc);
      check_val($sformatf("rr%0d_latency", i), 64'(cyc), 64'(11));
      check_val($sformatf("rr%0d_tag", i), 64'(tag_seen), 64'(13'h1100 | 13'(i % 2)));
      next_cycle_quiet($sformatf("rr%0d", i));
      if (i < 2) port_req[i % 2] = 1'b1;
    end
    port_req = '0;
    @(posedge clk); #1;

    // Stalled address ack plus gapped beats; port address changes after grant
    port_addr[63:0] = 64'h10FF; beat_base = 'hC0; ack_delay = 3; gap_en = 1; unstable = 0;
    port_req[0] = 1'b1;
    @(posedge clk); #1;
    port_addr[63:0] = 64'hFFFF_0000;
    wait_done(0, 2, cyc);
    check_val("stall_latency", 64'(cyc), 64'(21));
    check_val("stall_addr", addr_seen, 64'h10C0);
    check_val("stall_tag", 64'(tag_seen), 64'h1100);
    check_val("stall_stable", 64'(unstable), 64'(0));
    check_block("stall", 'hC0);
    next_cycle_quiet("stall");
    ack_delay = 0; gap_en = 0;

    // Stray response beats in IDLE are ignored
    junk_en = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val($sformatf("junk%0d_respack", i), 64'(bus_respack), 64'(0));
    end
    junk_en = 0;
    @(posedge clk); #1;
    check_val("junk_rdata", port_rdata[63:0], 64'hC0);

    // Reset in the middle of the read data phase
    beat_base = 'hD0; port_req[1] = 1'b1;
    for (int i = 0; i < 50 && rd_k != 4; i++) begin @(posedge clk); #1; end
    check_val("mid_beats", 64'(rd_k), 64'(4));
    reset = 1'b1; port_req = '0;
    @(posedge clk); #1;
    check_val("mid_done", 64'(port_done), 64'(0));
    check_val("mid_reqcyc", 64'(bus_reqcyc), 64'(0));
    check_val("mid_req", bus_req, 64'(0));
    check_val("mid_tag", 64'(bus_reqtag), 64'(0));
    check_val("mid_respack", 64'(bus_respack), 64'(0));
    check_val("mid_rdata", 64'(|port_rdata), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    port_addr[63:0] = 64'h1008; beat_base = 'hE0; port_req[0] = 1'b1;
    wait_done(0, 1, cyc);
    check_val("post_rst_latency", 64'(cyc), 64'(11));
    check_block("post_rst", 'hE0);
    next_cycle_quiet("post_rst");

`ifdef MEM_PORT_ARBITER_WRITE_EN
    // Block write from port 1; read data must stay untouched
    port_addr[127:64] = 64'h2000; port_wr = 2'b10; port_req[1] = 1'b1;
    wait_done(1, 1, cyc);
    check_val("wr_latency", 64'(cyc), 64'(11));
    check_val("wr_addr", addr_seen, 64'h2000);
    check_val("wr_tag", 64'(tag_seen), 64'h0101);
    for (int k = 0; k < int'(BEATS); k++)
      check_val($sformatf("wr_beat%0d", k), wr_log[k], 64'(8'hB0 + k));
    check_block("wr_keep", 'hE0);
    next_cycle_quiet("wr");
`else
    // Write request is serviced as a read when the write path is absent
    port_wr = 2'b11; beat_base = 'hF0; port_req[0] = 1'b1;
    wait_done(0, 1, cyc);
    check_val("ro_latency", 64'(cyc), 64'(11));
    check_val("ro_tag", 64'(tag_seen), 64'h1100);
    check_block("ro", 'hF0);
    next_cycle_quiet("ro");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter N_PORTS, default 2: number of requester ports (range 1..16).
REQ-002 Parameter BUS_DATA_WIDTH, default 64: bus beat width.
REQ-003 Parameter BUS_TAG_WIDTH, default 13: bus tag width.
REQ-004 Parameter BLOCKSZ, default 512: block size in bits; BEATS = BLOCKSZ/BUS_DATA_WIDTH.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 port_req  in  N_PORTS  per-port block request, held high until port_done.
REQ-008 port_wr  in  N_PORTS  per-port operation: 1 write, 0 read.
REQ-009 port_addr  in  N_PORTS*64  per-port byte address; port i occupies bits [64i+63:64i].
REQ-010 port_wdata  in  N_PORTS*BLOCKSZ  per-port write block; beat k is bits [k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH].
REQ-011 port_rdata  out  BLOCKSZ  last completed read block, shared by all ports.
REQ-012 port_done  out  N_PORTS  one-cycle completion pulse for the granted port.
REQ-013 bus_reqcyc  out  1  bus request valid.
REQ-014 bus_req  out  BUS_DATA_WIDTH  address in ADDR state, write beat in WDATA state, else 0.
REQ-015 bus_reqtag  out  BUS_TAG_WIDTH  {rw, 4'h1, grant index zero-extended to 8 bits}; rw 1 = read, 0 = write.
REQ-016 bus_reqack  in  1  bus accepted the current request or beat.
REQ-017 bus_respcyc, bus_resp, bus_resptag  in  1/BUS_DATA_WIDTH/BUS_TAG_WIDTH  read response beat; the tag is ignored.
REQ-018 bus_respack  out  1  response beat consumed.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, ADDR, WDATA, RDATA and DONE.
REQ-020 IDLE: if any port_req is set, the block SHALL grant round-robin starting from rr_ptr. It SHALL latch the grant index, port_wr, the block-aligned address (low log2(BLOCKSZ/8) bits cleared) and port_wdata, then go to ADDR.
REQ-021 ADDR: bus_reqcyc=1, with bus_req and bus_reqtag held stable; on bus_reqack go to WDATA if the latched rw is write, else RDATA; beat_cnt=0.
REQ-022 WDATA: bus_reqcyc=1 and bus_req=beat beat_cnt; each bus_reqack SHALL increment beat_cnt; the ack on beat BEATS-1 SHALL go to DONE.
REQ-023 RDATA: bus_respack SHALL equal bus_respcyc combinationally. Each bus_respcyc beat SHALL be stored at slot beat_cnt of port_rdata and increment beat_cnt; beat BEATS-1 SHALL go to DONE.
REQ-024 DONE: port_done[grant]=1 for one cycle; rr_ptr = (grant+1) mod N_PORTS; go to IDLE.
REQ-025 A requester SHALL drop port_req in its port_done cycle; the block SHALL sample port_req only in IDLE.
REQ-026 Minimum latency SHALL be 1 (grant) + 1 (address ack) + BEATS + 1 (done) cycles, measured from port_req high in IDLE to port_done.
REQ-027 bus_respcyc outside RDATA SHALL be ignored, with bus_respack=0.
REQ-028 bus_reqack outside ADDR and WDATA SHALL be ignored.
REQ-029 port_rdata SHALL be updated only by read beats; writes SHALL leave it unchanged.
REQ-030 Port input changes after grant SHALL have no effect until the next IDLE.

Reset
REQ-031 On reset the block SHALL force: state=IDLE, rr_ptr=0, beat_cnt=0, port_rdata=0, port_done=0, bus_reqcyc=0, bus_req=0, bus_reqtag=0, bus_respack=0.
REQ-032 Reset SHALL take priority in any state; an in-flight transfer SHALL be abandoned with no port_done.

Configuration
REQ-033 With macro MEM_PORT_ARBITER_WRITE_EN defined: the write path (WDATA state, wdata latch) SHALL be present as above.
REQ-034 Without MEM_PORT_ARBITER_WRITE_EN: WDATA and the wdata storage SHALL be removed, port_wr and port_wdata SHALL be ignored, and every request SHALL be serviced as a read with rw=1.

Verification
REQ-035 Read, N_PORTS=2: port0 reads 0x1008, bus acks at once and returns beats 0..7 = 0xA0..0xA7 -> bus_req=0x1000 and tag=0x1100; port_rdata beat k=0xA0+k; port_done[0] pulses at cycle 11.
REQ-036 Write (macro defined): port1 writes 0x2000, beats 0xB0..0xB7 -> tag=0x0101; bus_req sequence 0x2000, 0xB0..0xB7; port_done[1]; port_rdata unchanged.
REQ-037 Contention: port0 and port1 request together from reset -> port0 is served first, then port1; with both re-requesting, grants alternate 0,1,0,1.
REQ-038 Stall: bus_reqack delayed 3 cycles in ADDR and bus_respcyc gapped -> address and tag held stable; beats land in order; port_done arrives only after beat 7.
REQ-039 Reset at RDATA beat 4 -> next cycle all outputs are 0 and the FSM is IDLE; a subsequent read completes normally with no stale beats.
REQ-040 Macro undefined: port0 requests with port_wr=1 -> rw bit=1, read sequence performed, port_rdata updated.
